// File: rtl/mul_bist_ctrl.sv
// BIST sequencer for the Dadda multiplier: seeds two operand LFSRs,
// compacts products into a MISR and checks the result against a golden.
module mul_bist_ctrl #(
  parameter int N = 32,
  parameter int CNT_W = 16,
  parameter int MUL_LAT = 0,
  parameter logic [2*N-1:0] MISR_POLY = 64'h000000000000001B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [N-1:0]   seed_a,
  input  logic [N-1:0]   seed_b,
  input  logic [N-1:0]   mask,
  input  logic [2*N-1:0] golden,
  input  logic [2*N-1:0] prod,
  output logic           lfsr_rst,
  output logic [N-1:0]   lfsr_seed_a,
  output logic [N-1:0]   lfsr_seed_b,
  output logic [N-1:0]   lfsr_mask,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N-1:0] signature
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DRAIN, CHECK
  } state_t;

  localparam int PW = (MUL_LAT > 0) ? MUL_LAT : 1;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(PW - 1);
  localparam state_t AFTER_RUN = (MUL_LAT == 0) ? CHECK : DRAIN;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, num_q;
  logic [2*N-1:0] golden_q, misr_n;
  logic run, cap, kill;

  assign busy = (state != IDLE);
  assign run  = (state == RUN);
  assign kill = busy & abort;

  assign misr_n = {signature[2*N-2:0], 1'b0}
                ^ (signature[2*N-1] ? MISR_POLY : '0)
                ^ prod;

  // Capture enable follows RUN through the multiplier latency.
  if (MUL_LAT == 0) begin : g_comb
    assign cap = run;
  end else begin : g_pipe
    logic [MUL_LAT-1:0] pipe;
    always_ff @(posedge clk) begin
      if (rst || kill) pipe <= '0;
      else             pipe <= MUL_LAT'({pipe, run});
    end
    assign cap = pipe[MUL_LAT-1];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: begin
        if (num_q == '0) begin
          state_n = AFTER_RUN;
          cnt_n   = DRAIN_INIT;
        end else begin
          state_n = RUN;
          cnt_n   = num_q - 1'b1;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_n = AFTER_RUN;
          cnt_n   = DRAIN_INIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_n = CHECK;
        else           cnt_n   = cnt - 1'b1;
      end
      CHECK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      num_q       <= '0;
      golden_q    <= '0;
      lfsr_seed_a <= '0;
      lfsr_seed_b <= '0;
      lfsr_mask   <= '0;
      lfsr_rst    <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      signature   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lfsr_rst <= (state_n == LOAD);
      if (state == IDLE && start) begin
        num_q       <= num_vec;
        golden_q    <= golden;
        lfsr_seed_a <= seed_a;
        lfsr_seed_b <= seed_b;
        lfsr_mask   <= mask;
        signature   <= '0;
        done        <= 1'b0;
        pass        <= 1'b0;
      end else if (kill) begin
        done <= 1'b0;
        pass <= 1'b0;
      end else begin
        if (cap) signature <= misr_n;
        if (state == CHECK) begin
          pass <= (signature == golden_q);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_bist_ctrl.sv
// Bench for mul_bist_ctrl: two instances (latency 0 and 2) share the
// stimulus; a cycle-count model predicts every output each cycle.
module tb_mul_bist_ctrl;

  localparam int N  = 32;
  localparam int CW = 8;
  localparam logic [N-1:0] MSK = 32'h80200003;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic [N-1:0] seed_a = '0, seed_b = '0, mask = '0;
  logic [63:0] golden = '0;

  logic [63:0] prod [2];
  logic lrst [2], busy [2], done [2], pass [2];
  logic [N-1:0] lsa [2], lsb [2], lmk [2];
  logic [63:0] sig [2];

  int n_vec = 0;
  int n_err = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  mul_bist_ctrl #(.N(N), .CNT_W(CW), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_vec(num_vec), .seed_a(seed_a), .seed_b(seed_b),
    .mask(mask), .golden(golden), .prod(prod[0]),
    .lfsr_rst(lrst[0]), .lfsr_seed_a(lsa[0]),
    .lfsr_seed_b(lsb[0]), .lfsr_mask(lmk[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(sig[0])
  );

  mul_bist_ctrl #(.N(N), .CNT_W(CW), .MUL_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_vec(num_vec), .seed_a(seed_a), .seed_b(seed_b),
    .mask(mask), .golden(golden), .prod(prod[1]),
    .lfsr_rst(lrst[1]), .lfsr_seed_a(lsa[1]),
    .lfsr_seed_b(lsb[1]), .lfsr_mask(lmk[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(sig[1])
  );

  function automatic logic [N-1:0] lstep(
    input logic [N-1:0] v, input logic [N-1:0] m);
    return (v >> 1) ^ (v[0] ? m : '0);
  endfunction

  function automatic logic [63:0] mstep(
    input logic [63:0] s, input logic [63:0] p);
    return {s[62:0], 1'b0} ^ (s[63] ? 64'h1B : 64'h0) ^ p;
  endfunction

  function automatic logic [63:0] ref_sig(input int nv,
    input logic [N-1:0] a0, input logic [N-1:0] b0,
    input logic [N-1:0] m);
    logic [63:0] s;
    logic [N-1:0] a, b;
    s = '0; a = a0; b = b0;
    for (int k = 0; k < nv; k++) begin
      s = mstep(s, 64'(a) * 64'(b));
      a = lstep(a, m);
      b = lstep(b, m);
    end
    return s;
  endfunction

  // Operand LFSRs and multipliers around each controller
  logic [N-1:0] la [2], lb [2];
  logic [63:0] p1, p2;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (lrst[d]) begin
        la[d] <= lsa[d];
        lb[d] <= lsb[d];
      end else begin
        la[d] <= lstep(la[d], lmk[d]);
        lb[d] <= lstep(lb[d], lmk[d]);
      end
    end
    p1 <= 64'(la[1]) * 64'(lb[1]);
    p2 <= p1;
  end
  assign prod[0] = 64'(la[0]) * 64'(lb[0]);
  assign prod[1] = p2;

  // Model: cycle index c since the accepted start, signature table
  bit m_busy [2], m_done [2], m_pass [2];
  int m_c [2], m_nv [2];
  logic [63:0] m_sig [2], m_gold [2];
  logic [N-1:0] m_sa [2], m_sb [2], m_mk [2];
  logic [63:0] m_tab [2][0:255];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int ml, k;
      logic [N-1:0] a, b;
      ml = (d == 0) ? 0 : 2;
      if (rst) begin
        m_busy[d] = 0; m_done[d] = 0; m_pass[d] = 0;
        m_c[d] = 0; m_sig[d] = '0;
        m_sa[d] = '0; m_sb[d] = '0; m_mk[d] = '0;
      end else if (!m_busy[d]) begin
        if (start) begin
          m_nv[d] = int'(num_vec);
          m_gold[d] = golden;
          m_sa[d] = seed_a; m_sb[d] = seed_b; m_mk[d] = mask;
          m_busy[d] = 1; m_done[d] = 0; m_pass[d] = 0;
          m_c[d] = 1;
          a = seed_a; b = seed_b;
          m_tab[d][0] = '0;
          for (k = 0; k < m_nv[d]; k++) begin
            m_tab[d][k+1] = mstep(m_tab[d][k], 64'(a) * 64'(b));
            a = lstep(a, mask);
            b = lstep(b, mask);
          end
        end
      end else if (abort) begin
        m_busy[d] = 0; m_done[d] = 0; m_pass[d] = 0;
      end else begin
        m_c[d]++;
        if (m_c[d] == m_nv[d] + ml + 3) begin
          m_busy[d] = 0;
          m_done[d] = 1;
          m_pass[d] = (m_tab[d][m_nv[d]] == m_gold[d]);
        end
      end
      if (m_busy[d]) begin
        k = m_c[d] - 2 - ml;
        if (k < 0) k = 0;
        if (k > m_nv[d]) k = m_nv[d];
        m_sig[d] = m_tab[d][k];
      end
    end
  end

  task automatic chk(input string nm, input int d,
    input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h want %0h t=%0t",
               nm, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, busy[d], m_busy[d]);
        chk("done", d, done[d], m_done[d]);
        chk("pass", d, pass[d], m_pass[d]);
        chk("lfsr_rst", d, lrst[d], m_busy[d] && m_c[d] == 1);
        chk("signature", d, sig[d], m_sig[d]);
        chk("seed_a", d, lsa[d], m_sa[d]);
        chk("seed_b", d, lsb[d], m_sb[d]);
        chk("mask", d, lmk[d], m_mk[d]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns 2 time units into cycle 1 (LOAD)
  task automatic go(input int nv, input logic [N-1:0] a,
    input logic [N-1:0] b, input logic [63:0] g);
    num_vec = CW'(nv);
    seed_a = a;
    seed_b = b;
    mask = MSK;
    golden = g;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((busy[0] || busy[1]) && i < budget) begin
      cyc(1);
      i++;
    end
    chk("idle_wait", 0, busy[0] | busy[1], 0);
    cyc(1);
  endtask

  initial begin
    logic [63:0] g;
    cyc(1);
    armed = 1;
    cyc(1);
    chk("rst_done", 0, done[0], 0);
    chk("rst_sig", 1, sig[1], 0);
    chk("rst_lrst", 0, lrst[0], 0);
    rst = 1'b0;
    cyc(2);

    // single vector, passing and failing golden
    go(1, 32'h1, 32'h1, 64'h1);
    chk("t1_lrst_c1", 0, lrst[0], 1);
    cyc(1);
    chk("t1_lrst_c2", 0, lrst[0], 0);
    cyc(1);
    chk("t1_done_c3", 0, done[0], 0);
    cyc(1);
    chk("t1_done_c4", 0, done[0], 1);
    chk("t1_pass_c4", 0, pass[0], 1);
    chk("t1_sig", 0, sig[0], 64'h1);
    wait_idle(20);

    go(1, 32'h1, 32'h1, 64'h2);
    cyc(3);
    chk("t2_done", 0, done[0], 1);
    chk("t2_pass", 0, pass[0], 0);
    chk("t2_sig", 0, sig[0], 64'h1);
    wait_idle(20);

    // zero vectors
    go(0, 32'h5, 32'h7, 64'h0);
    cyc(1);
    chk("t3_done_c2", 0, done[0], 0);
    cyc(1);
    chk("t3_done_c3", 0, done[0], 1);
    chk("t3_pass_c3", 0, pass[0], 1);
    chk("t3_sig", 0, sig[0], 64'h0);
    cyc(2);
    chk("t3_done_l2", 1, done[1], 1);
    wait_idle(20);
    go(0, 32'h5, 32'h7, 64'h5);
    cyc(2);
    chk("t3b_done", 0, done[0], 1);
    chk("t3b_pass", 0, pass[0], 0);
    wait_idle(20);

    // pipelined multiplier, 4 vectors
    g = ref_sig(4, 32'hDEADBEEF, 32'h12345678, MSK);
    go(4, 32'hDEADBEEF, 32'h12345678, g);
    cyc(7);
    chk("t4_done_c8", 1, done[1], 0);
    cyc(1);
    chk("t4_done_c9", 1, done[1], 1);
    chk("t4_pass_c9", 1, pass[1], 1);
    chk("t4_sig", 1, sig[1], g);
    wait_idle(20);

    // restart attempt during RUN is ignored
    g = ref_sig(100, 32'hCAFEF00D, 32'h0BADC0DE, MSK);
    go(100, 32'hCAFEF00D, 32'h0BADC0DE, g);
    cyc(19);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(81);
    chk("t5_done_c102", 0, done[0], 0);
    cyc(1);
    chk("t5_done_c103", 0, done[0], 1);
    chk("t5_pass", 0, pass[0], 1);
    wait_idle(20);

    // abort at RUN cycle 10
    go(100, 32'h13579BDF, 32'h2468ACE0, 64'h0);
    cyc(11);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t6_busy", 0, busy[0], 0);
    chk("t6_done", 0, done[0], 0);
    chk("t6_pass", 0, pass[0], 0);
    chk("t6_lrst", 0, lrst[0], 0);
    chk("t6_busy_l2", 1, busy[1], 0);
    cyc(2);

    // reset during DRAIN, then a clean rerun
    go(3, 32'h0F0F0F0F, 32'h33333333, 64'h0);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t7_sig", 1, sig[1], 0);
    chk("t7_busy", 1, busy[1], 0);
    chk("t7_seed", 1, lsa[1], 0);
    cyc(2);
    g = ref_sig(3, 32'h0F0F0F0F, 32'h33333333, MSK);
    go(3, 32'h0F0F0F0F, 32'h33333333, g);
    cyc(7);
    chk("t7_done_c8", 1, done[1], 1);
    chk("t7_pass_c8", 1, pass[1], 1);
    wait_idle(20);

    // full-scale vector count
    g = ref_sig(255, 32'h89ABCDEF, 32'h76543210, MSK);
    go(255, 32'h89ABCDEF, 32'h76543210, g);
    cyc(256);
    chk("t8_done_c257", 0, done[0], 0);
    cyc(1);
    chk("t8_done_c258", 0, done[0], 1);
    chk("t8_pass", 0, pass[0], 1);
    wait_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_bist_ctrl.md
# mul_bist_ctrl

Built-in self-test sequencer for the 32-bit Dadda multiplier. It loads seeds and masks into two operand LFSRs and lets them free-run for a programmed number of vectors. Each multiplier product is compacted into a MISR signature, which is compared against a golden value. The block sits between the test-configuration registers and the LFSR → multiplier datapath, and reports busy/done/pass to the host.

## Interface
- N, 32, operand width; product and signature width is 2N
- CNT_W, 16, width of vector count
- MUL_LAT, 0, multiplier pipeline latency in clk cycles (0 = combinational)
- MISR_POLY, 64'h000000000000001B, MISR feedback taps (x^64+x^4+x^3+x+1), 2N bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle start pulse; sampled only in IDLE
- abort  in  1  cancel a running test
- num_vec  in  CNT_W  vectors to apply; latched at start
- seed_a, seed_b  in  N  LFSR seeds; latched at start
- mask  in  N  LFSR tap mask, shared by both LFSRs; latched at start
- golden  in  2N  expected signature; latched at start
- prod  in  2N  multiplier product
- lfsr_rst  out  1  drives rst of both LFSRs
- lfsr_seed_a, lfsr_seed_b, lfsr_mask  out  N  latched config, driven to the LFSRs
- busy  out  1  high in LOAD/RUN/DRAIN/CHECK
- done  out  1  sticky test-complete flag
- pass  out  1  valid when done=1; signature == golden
- signature  out  2N  current MISR value

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, CHECK. The LFSRs have no enable, so they advance every cycle that lfsr_rst=0.
- IDLE with start=1:
  - latch the config inputs
  - clear signature, done and pass
  - go to LOAD
- start is ignored while busy=1.
- LOAD lasts 1 cycle with lfsr_rst=1 (registered output), so the LFSRs load their seeds at the end of LOAD. Next state is RUN, or DRAIN if num_vec=0.
- RUN lasts num_vec cycles. Operand vector k (k=0..num_vec-1) is the LFSR output in RUN cycle k; vector 0 equals the seeds.
- Capture enable is the RUN indicator delayed by MUL_LAT cycles through a shift register. Each capture-enabled cycle updates the MISR at the clock edge: sig ← {sig[2N-2:0],0} ^ (sig[2N-1] ? MISR_POLY : 0) ^ prod.
- DRAIN lasts MUL_LAT cycles (0 = skipped), then goes to CHECK. No captures occur when num_vec=0.
- CHECK lasts 1 cycle: register pass ← (signature == golden) and done ← 1, then return to IDLE.
- abort=1 in any busy state:
  - next state IDLE, lfsr_rst=0
  - done=0, pass=0
  - capture pipeline flushed
  - signature holds its value
- abort in IDLE has no effect. abort takes priority over every other transition.
- The vector counter is CNT_W bits. num_vec = 2^CNT_W-1 is legal; the counter must not wrap early.

## Timing
- Reset values:
  - state IDLE, lfsr_rst=0, busy=0, done=0, pass=0
  - signature=0, capture pipeline=0
  - lfsr_seed_a, lfsr_seed_b, lfsr_mask = 0
- Edge E0 samples start. Then:
  - LOAD is cycle 1 after E0.
  - RUN is cycles 2..num_vec+1.
  - DRAIN follows for MUL_LAT cycles.
  - CHECK follows for 1 cycle.
- done and pass rise num_vec+MUL_LAT+3 cycles after E0. busy falls in the same cycle.
- done and pass hold until the next accepted start or rst.
- A new start is accepted in the first cycle done=1.
- The last capture happens at the edge ending cycle num_vec+MUL_LAT+1, so signature is final while in CHECK.
- rst mid-run returns every output to its reset value at the next edge; no partial result is reported.

## Test plan
- MUL_LAT=0, seed_a=seed_b=1, mask=32'h80200003, num_vec=1, bench prod=a*b=1, golden=1 -> signature=64'h1; done=pass=1 at cycle 4 after E0; lfsr_rst high only in cycle 1.
- Same setup with golden=2 -> done=1, pass=0, signature=64'h1.
- num_vec=0, golden=0 -> no capture, done=pass=1 at cycle 3; golden=5 -> pass=0.
- MUL_LAT=2, num_vec=4, bench multiplier with a 2-cycle pipeline, golden computed by the reference model -> exactly 4 captures, done=pass=1 at cycle 9.
- num_vec=100:
  - start pulsed again mid-RUN -> ignored, completion timing unchanged.
  - abort at RUN cycle 10 -> IDLE next cycle, busy=done=pass=0, lfsr_rst=0.
- rst asserted during DRAIN -> all outputs reset next cycle; a subsequent start runs a fresh test to a correct pass.
